// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the 16-bit LFSR word generator and its checker.
//   LFSR_W    : word width (16)
//   TAP_MASK  : bits of the word that feed the parity (all odd bits)
//   FB_INV    : the parity is inverted so an all-zero history still advances
//   lfsr_fb   : feedback bit f(x) = ^(x & TAP_MASK) ^ FB_INV
//   lfsr_next : next word from the two most recent words
//   lfsr_state_e : checker state encoding (HUNT / SYNC / LOCKED)
// Optional feature macro used by the checker: LFSR_CHK_BITERR_EN
// -----------------------------------------------------------------------------
package lfsr_pkg;

    localparam int LFSR_W = 16;

    localparam logic [LFSR_W-1:0] TAP_MASK = 16'hAAAA;
    localparam logic              FB_INV   = 1'b1;

    // Width of the consecutive good/bad run counters; the lock and loss
    // thresholds are limited to 1..255.
    localparam int RUN_W = 8;

    // Width of a per-word bit-error count (0..16).
    localparam int POP_W = 5;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } lfsr_state_e;

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] x);
        return (^(x & TAP_MASK)) ^ FB_INV;
    endfunction

    // h1 is the newest word, h2 the one before it.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] h1,
                                                     input logic [LFSR_W-1:0] h2);
        return {h1[LFSR_W-2:0], lfsr_fb(h2)};
    endfunction

endpackage

// File: rtl/lfsr_predict.sv
// -----------------------------------------------------------------------------
// lfsr_predict
// Purely combinational word predictor for the LFSR checker.
// Ports:
//   h1       in  16  most recently accepted word
//   h2       in  16  word accepted before h1
//   data_in  in  16  received word (only with LFSR_CHK_BITERR_EN)
//   pop_cnt  out 5   number of bits in which data_in differs from the
//                    prediction (only with LFSR_CHK_BITERR_EN)
//   pred     out 16  predicted next word
// Optional feature macro: LFSR_CHK_BITERR_EN
// -----------------------------------------------------------------------------
module lfsr_predict
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] h1,
    input  logic [LFSR_W-1:0] h2,
`ifdef LFSR_CHK_BITERR_EN
    input  logic [LFSR_W-1:0] data_in,
    output logic [POP_W-1:0]  pop_cnt,
`endif
    output logic [LFSR_W-1:0] pred
);

    assign pred = lfsr_next(h1, h2);

`ifdef LFSR_CHK_BITERR_EN
    logic [LFSR_W-1:0] diff;

    assign diff = data_in ^ pred;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < LFSR_W; i++) begin
            pop_cnt = pop_cnt + POP_W'(diff[i]);
        end
    end
`endif

endmodule

// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
// Receive-side checker for the 16-bit LFSR word stream. It keeps the last two
// received words as history, predicts the next word from them, locks after
// LOCK_CNT consecutive correct predictions and, while locked, counts words
// that do not match the prediction. Because the history is always loaded with
// the words actually received, the checker resynchronises by itself.
//
// Parameters:
//   LOCK_CNT  consecutive matches in SYNC needed for lock (1..255)
//   LOSS_CNT  consecutive mismatches in LOCKED that drop lock (1..255)
//   CNT_W     width of the saturating error counters
// Ports:
//   clk          in   1      clock, rising edge
//   rst          in   1      synchronous, active-high reset
//   ce           in   1      word strobe
//   data_in      in   16     received word
//   clr_cnt      in   1      synchronous clear of the error counters
//   locked       out  1      high while in LOCKED
//   err_pulse    out  1      one-cycle pulse per counted word error
//   err_cnt      out  CNT_W  saturating count of mispredicted words in LOCKED
//   bit_err_cnt  out  CNT_W  saturating count of wrong bits in LOCKED
//                            (only with LFSR_CHK_BITERR_EN)
//   state_dbg    out  2      current state encoding (0 HUNT, 1 SYNC, 2 LOCKED)
//
// Word interface: ce is a one-way strobe with no backpressure. A word is
// accepted on every rising edge where ce=1; the checker can always take it,
// and nothing at all changes on an edge where ce=0 apart from clr_cnt.
//
// Optional feature macro: LFSR_CHK_BITERR_EN adds bit_err_cnt.
// -----------------------------------------------------------------------------
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [LFSR_W-1:0] data_in,
    input  logic              clr_cnt,
    output logic              locked,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  err_cnt,
`ifdef LFSR_CHK_BITERR_EN
    output logic [CNT_W-1:0]  bit_err_cnt,
`endif
    output logic [1:0]        state_dbg
);

    localparam logic [RUN_W-1:0] LOCK_TARGET = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0] LOSS_TARGET = RUN_W'(LOSS_CNT);

    lfsr_state_e state;
    lfsr_state_e next_state;

    logic [LFSR_W-1:0] h1;
    logic [LFSR_W-1:0] h2;
    logic [LFSR_W-1:0] pred;
    logic              match;

    // HUNT only needs to know whether one word has already been seen.
    logic              hunt_seen;
    logic              hunt_seen_nxt;

    logic [RUN_W-1:0]  good_cnt;
    logic [RUN_W-1:0]  good_nxt;
    logic [RUN_W-1:0]  good_inc;
    logic [RUN_W-1:0]  bad_cnt;
    logic [RUN_W-1:0]  bad_nxt;
    logic [RUN_W-1:0]  bad_inc;

    logic              err_hit;
    logic              locked_nxt;
    logic              err_pulse_nxt;
    logic [CNT_W-1:0]  err_base;
    logic [CNT_W-1:0]  err_cnt_nxt;

    // ------------------------------------------------------------------
    // Prediction
    // ------------------------------------------------------------------
`ifdef LFSR_CHK_BITERR_EN
    logic [POP_W-1:0]       pop_cnt;
    logic                   bit_hit;
    logic [CNT_W-1:0]       bit_base;
    logic [CNT_W+POP_W-1:0] bit_sum;
    logic [CNT_W-1:0]       bit_err_nxt;

    lfsr_predict u_predict (
        .h1      (h1),
        .h2      (h2),
        .data_in (data_in),
        .pop_cnt (pop_cnt),
        .pred    (pred)
    );
`else
    lfsr_predict u_predict (
        .h1   (h1),
        .h2   (h2),
        .pred (pred)
    );
`endif

    assign match    = (data_in == pred);
    assign good_inc = good_cnt + RUN_W'(1);
    assign bad_inc  = bad_cnt + RUN_W'(1);

    assign state_dbg = state;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_HUNT;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and run counters
    // ------------------------------------------------------------------
    always_comb begin
        next_state    = state;
        hunt_seen_nxt = hunt_seen;
        good_nxt      = good_cnt;
        bad_nxt       = bad_cnt;
        if (ce) begin
            unique case (state)
                ST_HUNT: begin
                    // Two words fill the history; predictions are valid after.
                    if (hunt_seen) begin
                        next_state    = ST_SYNC;
                        hunt_seen_nxt = 1'b0;
                        good_nxt      = '0;
                    end else begin
                        hunt_seen_nxt = 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (match) begin
                        good_nxt = good_inc;
                        if (good_inc == LOCK_TARGET) begin
                            next_state = ST_LOCKED;
                            bad_nxt    = '0;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    if (match) begin
                        bad_nxt = '0;
                    end else begin
                        bad_nxt = bad_inc;
                        if (bad_inc == LOSS_TARGET) begin
                            next_state = ST_SYNC;
                            good_nxt   = '0;
                        end
                    end
                end
                default: begin
                    next_state = ST_HUNT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (values loaded into the output registers)
    // ------------------------------------------------------------------
    always_comb begin
        // Only words judged while already LOCKED are counted, including the
        // one that causes the loss of lock.
        err_hit       = ce && (state == ST_LOCKED) && !match;
        locked_nxt    = (next_state == ST_LOCKED);
        err_pulse_nxt = err_hit;

        // Clear first, then count: clr_cnt with an error leaves 1.
        err_base    = clr_cnt ? '0 : err_cnt;
        err_cnt_nxt = err_base;
        if (err_hit && (err_base != {CNT_W{1'b1}})) begin
            err_cnt_nxt = err_base + CNT_W'(1);
        end
    end

`ifdef LFSR_CHK_BITERR_EN
    always_comb begin
        bit_hit     = ce && (state == ST_LOCKED);
        bit_base    = clr_cnt ? '0 : bit_err_cnt;
        bit_sum     = {{POP_W{1'b0}}, bit_base} + {{CNT_W{1'b0}}, pop_cnt};
        bit_err_nxt = bit_base;
        if (bit_hit) begin
            // The wide sum exposes any overflow past all-ones.
            if (bit_sum > {{POP_W{1'b0}}, {CNT_W{1'b1}}}) begin
                bit_err_nxt = {CNT_W{1'b1}};
            end else begin
                bit_err_nxt = bit_sum[CNT_W-1:0];
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            h1        <= '0;
            h2        <= '0;
            hunt_seen <= 1'b0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
`ifdef LFSR_CHK_BITERR_EN
            bit_err_cnt <= '0;
`endif
        end else begin
            // History always follows the received words, in every state.
            if (ce) begin
                h2 <= h1;
                h1 <= data_in;
            end
            hunt_seen <= hunt_seen_nxt;
            good_cnt  <= good_nxt;
            bad_cnt   <= bad_nxt;
            locked    <= locked_nxt;
            err_pulse <= err_pulse_nxt;
            err_cnt   <= err_cnt_nxt;
`ifdef LFSR_CHK_BITERR_EN
            bit_err_cnt <= bit_err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_checker
// Self-checking bench for lfsr_checker: a literal table for reset and the
// first lock, a reference model of the checker rules fed from a behavioural
// word generator, and hand-written sequences for errors, clears, ce gaps,
// loss of lock, saturation (second instance with CNT_W=4) and reset.
// -----------------------------------------------------------------------------
module tb_lfsr_checker;

    localparam int LOCK_CNT = 8;
    localparam int LOSS_CNT = 4;
    localparam int CNT_W    = 16;

    // ---------------- clock / reset block ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [15:0] data_in = 16'h0;

    always #5 clk = ~clk;

    logic        locked, err_pulse;
    logic [15:0] err_cnt;
    logic [1:0]  state_dbg;
    logic        locked_s, err_pulse_s;
    logic [3:0]  err_cnt_s;
    logic [1:0]  state_dbg_s;
`ifdef LFSR_CHK_BITERR_EN
    logic [15:0] bit_err_cnt;
    logic [3:0]  bit_err_cnt_s;
`endif

    lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .data_in   (data_in),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
`ifdef LFSR_CHK_BITERR_EN
        .bit_err_cnt (bit_err_cnt),
`endif
        .state_dbg (state_dbg)
    );

    // Narrow counter, lenient loss threshold: used for the saturation run.
    lfsr_checker #(.LOCK_CNT(8), .LOSS_CNT(32), .CNT_W(4)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .data_in   (data_in),
        .clr_cnt   (clr_cnt),
        .locked    (locked_s),
        .err_pulse (err_pulse_s),
        .err_cnt   (err_cnt_s),
`ifdef LFSR_CHK_BITERR_EN
        .bit_err_cnt (bit_err_cnt_s),
`endif
        .state_dbg (state_dbg_s)
    );

    // ---------------- counters ----------------
    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural generator ----------------
    int          g_cnt;
    logic [15:0] g_a, g_b;   // g_a newest emitted word, g_b the one before

    function automatic logic parity_fb(input logic [15:0] x);
        return ($countones(x & 16'hAAAA) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic gen_reset();
        g_cnt = 0; g_a = 16'h0; g_b = 16'h0;
    endtask

    task automatic gen_word(output logic [15:0] w);
        if (g_cnt < 2) w = 16'h0;
        else           w = ((g_a * 2) & 16'hFFFF) | 16'(parity_fb(g_b));
        g_b = g_a;
        g_a = w;
        g_cnt++;
    endtask

    // ---------------- reference model + scoreboard ----------------
    // Mode: 0 hunting, 1 syncing, 2 locked. Run lengths of good/bad words.
    int          m_mode, m_seen, m_good, m_bad;
    logic [15:0] m_hist[$];
    logic [15:0] m_err;
    logic [15:0] m_bit;
    logic [17:0] exp_q[$];  // {locked, err_pulse, err_cnt}

    task automatic model_step(input logic r, input logic c, input logic cl, input logic [15:0] d);
        logic [15:0] p;
        logic        hit;
        int          pc;
        hit = 1'b0;
        if (r) begin
            m_hist = '{16'h0, 16'h0};
            m_mode = 0; m_seen = 0; m_good = 0; m_bad = 0;
            m_err = 16'h0; m_bit = 16'h0;
            exp_q.push_back({1'b0, 1'b0, 16'h0});
            return;
        end
        if (cl) begin
            m_err = 16'h0;
            m_bit = 16'h0;
        end
        if (c) begin
            p = ((m_hist[1] * 2) & 16'hFFFF) | 16'(parity_fb(m_hist[0]));
            if (m_mode == 0) begin
                m_seen++;
                if (m_seen == 2) begin m_mode = 1; m_good = 0; end
            end else if (m_mode == 1) begin
                if (d == p) begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin m_mode = 2; m_bad = 0; end
                end else m_good = 0;
            end else begin
                pc = $countones(d ^ p);
                m_bit = (int'(m_bit) + pc > 65535) ? 16'hFFFF : 16'(int'(m_bit) + pc);
                if (d == p) m_bad = 0;
                else begin
                    hit = 1'b1;
                    m_bad++;
                    if (m_bad == LOSS_CNT) begin m_mode = 1; m_good = 0; end
                end
            end
            m_hist.push_back(d);
            void'(m_hist.pop_front());
        end
        if (hit && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        exp_q.push_back({(m_mode == 2) ? 1'b1 : 1'b0, hit, m_err});
    endtask

    task automatic check_model();
        logic [17:0] e;
        if (exp_q.size() == 0) begin
            n_vec++; n_mis++;
            $display("FAIL model_queue: got empty, expected entry");
            return;
        end
        e = exp_q.pop_front();
        check("model_locked", 32'(locked), 32'(e[17]));
        check("model_err_pulse", 32'(err_pulse), 32'(e[16]));
        check("model_err_cnt", 32'(err_cnt), 32'(e[15:0]));
`ifdef LFSR_CHK_BITERR_EN
        check("model_bit_err_cnt", 32'(bit_err_cnt), 32'(m_bit));
`endif
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic c, input logic cl, input logic [15:0] d);
        rst = r; ce = c; clr_cnt = cl; data_in = d;
        @(posedge clk);
        #1;
        model_step(r, c, cl, d);
    endtask

    task automatic clean_word(input logic cl);
        logic [15:0] w;
        gen_word(w);
        step(1'b0, 1'b1, cl, w);
        check_model();
    endtask

    task automatic flip_word(input logic cl, input logic [15:0] mask);
        logic [15:0] w;
        gen_word(w);
        step(1'b0, 1'b1, cl, w ^ mask);
        check_model();
    endtask

    // ---------------- table of reset + first lock ----------------
    typedef struct {
        logic        r;
        logic [15:0] d;
        logic        e_locked;
        logic        e_pulse;
        logic [15:0] e_err;
        logic [1:0]  e_state;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int          acc;
        logic        c;
        int          n;

        tbl[0]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 2'd0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 2'd0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 2'd1};
        tbl[3]  = '{1'b0, 16'h0001, 1'b0, 1'b0, 16'h0, 2'd1};
        tbl[4]  = '{1'b0, 16'h0003, 1'b0, 1'b0, 16'h0, 2'd1};
        tbl[5]  = '{1'b0, 16'h0007, 1'b0, 1'b0, 16'h0, 2'd1};
        tbl[6]  = '{1'b0, 16'h000E, 1'b0, 1'b0, 16'h0, 2'd1};
        tbl[7]  = '{1'b0, 16'h001C, 1'b0, 1'b0, 16'h0, 2'd1};
        tbl[8]  = '{1'b0, 16'h0039, 1'b0, 1'b0, 16'h0, 2'd1};
        tbl[9]  = '{1'b0, 16'h0072, 1'b0, 1'b0, 16'h0, 2'd1};
        tbl[10] = '{1'b0, 16'h00E5, 1'b1, 1'b0, 16'h0, 2'd2};
        tbl[11] = '{1'b0, 16'h01CB, 1'b1, 1'b0, 16'h0, 2'd2};
        tbl[12] = '{1'b0, 16'h0397, 1'b1, 1'b0, 16'h0, 2'd2};

        // Table: reset, then the clean stream up to and past lock.
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, 1'b1, 1'b0, tbl[i].d);
            void'(exp_q.pop_front());
            check("tbl_locked", 32'(locked), 32'(tbl[i].e_locked));
            check("tbl_err_pulse", 32'(err_pulse), 32'(tbl[i].e_pulse));
            check("tbl_err_cnt", 32'(err_cnt), 32'(tbl[i].e_err));
            check("tbl_state", 32'(state_dbg), 32'(tbl[i].e_state));
        end
        g_cnt = 12; g_a = 16'h0397; g_b = 16'h01CB;

        // Long clean run: no errors.
        for (int i = 0; i < 1000; i++) clean_word(1'b0);
        check("clean_err_cnt", 32'(err_cnt), 32'd0);

        // Single bit-5 flip while locked: three mispredicted words, lock held.
        flip_word(1'b0, 16'h0020);
        check("flip_pulse", 32'(err_pulse), 32'd1);
        check("flip_err_cnt1", 32'(err_cnt), 32'd1);
        for (int i = 0; i < 4; i++) clean_word(1'b0);
        check("flip_err_cnt3", 32'(err_cnt), 32'd3);
        check("flip_locked", 32'(locked), 32'd1);

        // clr_cnt on the same edge as an error, then clr_cnt alone.
        flip_word(1'b1, 16'h0020);
        check("clr_with_err", 32'(err_cnt), 32'd1);
        for (int i = 0; i < 3; i++) clean_word(1'b0);
        check("clr_err_after", 32'(err_cnt), 32'd3);
        clean_word(1'b1);
        check("clr_alone", 32'(err_cnt), 32'd0);
        check("clr_keeps_lock", 32'(locked), 32'd1);

        // ce gaps (30% duty): lock at exactly 10 accepted words, no errors.
        step(1'b1, 1'b0, 1'b0, 16'hFFFF);
        check_model();
        gen_reset();
        acc = 0;
        for (int i = 0; i < 600 && acc < 40; i++) begin
            c = ($urandom_range(0, 99) < 30);
            if (c) begin
                gen_word(w);
                acc++;
            end else begin
                w = 16'($urandom);
            end
            step(1'b0, c, 1'b0, w);
            check_model();
            check("gap_lock_point", 32'(locked), (acc >= 10) ? 32'd1 : 32'd0);
            if (!c) check("gap_pulse_idle", 32'(err_pulse), 32'd0);
        end
        check("gap_accepted", 32'(acc), 32'd40);
        check("gap_err_cnt", 32'(err_cnt), 32'd0);

        // Constant 1234 while locked: lock lost after 4 words, 4 counted.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h1234);
            check_model();
            if (i == 2) check("const_locked3", 32'(locked), 32'd1);
        end
        check("const_unlocked", 32'(locked), 32'd0);
        check("const_err_cnt", 32'(err_cnt), 32'd4);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h1234);
            check_model();
        end
        check("const_no_count", 32'(err_cnt), 32'd4);
        check("const_state_sync", 32'(state_dbg), 32'd1);
        check("sat_err_cnt", 32'(err_cnt_s), 32'd15);
        check("sat_locked", 32'(locked_s), 32'd1);

        // Reset while locked, then relock on the continuing stream.
        step(1'b1, 1'b0, 1'b0, 16'h0);
        check_model();
        gen_reset();
        for (int i = 0; i < 12; i++) clean_word(1'b0);
        check("pre_rst_locked", 32'(locked), 32'd1);
        flip_word(1'b0, 16'h0100);
        check("pre_rst_err", 32'(err_cnt), 32'd1);
        step(1'b1, 1'b1, 1'b0, 16'hBEEF);
        check_model();
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        n = 0;
        while (n < 40 && locked !== 1'b1) begin
            clean_word(1'b0);
            n++;
        end
        check("relock_words", 32'(n), 32'd10);

        // Random mix: ce duty, corrupted words, clears and rare resets.
        for (int i = 0; i < 2000; i++) begin
            c = ($urandom_range(0, 99) < 70);
            if (c) begin
                gen_word(w);
                if ($urandom_range(0, 99) < 5) w = w ^ (16'd1 << $urandom_range(0, 15));
            end else begin
                w = 16'($urandom);
            end
            step(($urandom_range(0, 999) < 5), c, ($urandom_range(0, 99) < 3), w);
            check_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive end of the 16-bit pseudo-random word stream produced by the team's LFSR generator.
- Self-synchronises to the incoming words, declares lock, and counts word errors while locked.
- Sits next to the generator output, or after a transport path, as a pattern checker for link and board tests.

Parameters:
- LOCK_CNT, 8: consecutive correctly predicted words required to declare lock (1..255).
- LOSS_CNT, 4: consecutive mispredicted words in LOCKED that drop lock (1..255).
- CNT_W, 16: width of the saturating error counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ce  in  1  word strobe; data_in is sampled only when ce=1.
- data_in  in  16  received generator word.
- clr_cnt  in  1  synchronous clear of err_cnt (and bit_err_cnt if present).
- locked  out  1  1 while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mispredicted word while LOCKED.
- err_cnt  out  CNT_W  saturating count of mispredicted words while LOCKED.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values: locked=0, err_pulse=0, err_cnt=0, history registers=0, good/bad counters=0, state=HUNT.
- Recurrence, with w(n) the n-th accepted word and f(x) = x[15]^x[13]^x[11]^x[9]^x[7]^x[5]^x[3]^x[1]^1:
  - predicted p(n+1) = {w(n)[14:0], f(w(n-1))}.
  - history h1=w(n) and h2=w(n-1).
- History update: on every accepted word (ce=1), h2<=h1 and h1<=data_in, in every state, using the actual received word. This is what makes the checker self-synchronising.
- match = (data_in == p), evaluated only in SYNC and LOCKED.
- State machine:
  - HUNT: counts accepted words. After 2 accepted words, go to SYNC with good=0.
  - SYNC:
    - match: good++. When good reaches LOCK_CNT, go to LOCKED with bad=0.
    - mismatch: good=0, stay in SYNC.
  - LOCKED:
    - match: bad=0.
    - mismatch: err_pulse=1 on the next cycle, err_cnt +1 saturating at all-ones, bad++.
    - When bad reaches LOSS_CNT, go to SYNC with good=0 and locked=0. The error that causes the loss is still counted.
- ce=0: no state, counter or history change; err_pulse=0.
- Latency: for a word accepted at edge k, locked, err_pulse and err_cnt reflect it right after edge k.
- Errors are counted only in LOCKED. Mismatches in HUNT and SYNC are not counted.
- clr_cnt and a counted error in the same cycle: err_cnt=1 (clear, then count). clr_cnt alone: err_cnt=0. clr_cnt does not affect state or lock.
- rst mid-stream overrides everything: state returns to HUNT and all registers take their reset values on that edge.

Optional Feature:
- Macro LFSR_CHK_BITERR_EN.
- Defined:
  - Adds output bit_err_cnt, width CNT_W.
  - In LOCKED, on each accepted word, adds popcount(data_in ^ p) (0..16), saturating at all-ones.
  - Cleared by rst and clr_cnt; the same clear-then-count rule applies.
- Undefined: the port and the popcount logic are absent; all other behaviour is identical.

Decomposition:
- Shared package lfsr_pkg holds:
  - LFSR_W=16.
  - Tap mask 16'hAAAA and feedback invert constant 1, shared with the generator.
  - The feedback function f.
  - State encoding HUNT/SYNC/LOCKED.
- One natural sub-module: lfsr_predict. It is combinational: from h1 and h2 it produces p and, when the macro is defined, the popcount of (data_in ^ p).

Test Plan:
- Clean stream: generator from reset gives 0000,0000,0001,0003,0007,000E,... with ce every cycle.
  - locked rises after 2+LOCK_CNT=10 accepted words.
  - err_cnt stays 0 over 1000 words.
- Single-bit flip while locked: data_in bit 5 is inverted on one word.
  - err_pulse fires once; err_cnt=1.
  - The corrupted word enters history, so the next 1-2 words also mispredict. err_cnt ends at 3.
  - Lock is held because LOSS_CNT=4 is not reached.
- Stream replaced by a constant 16'h1234 while locked.
  - Every word mispredicts; locked falls after 4 words; err_cnt=4.
  - Then SYNC, with no further counting.
- ce gaps: random ce duty of 30% on a clean stream.
  - Identical lock point in accepted words; no errors.
  - err_pulse is never asserted on a ce=0 cycle.
- clr_cnt at the same edge as an error → err_cnt=1. A saturation run with CNT_W=4 holds err_cnt at 15.
- rst asserted while locked → next cycle: locked=0, err_cnt=0, state HUNT. Relock takes exactly 10 more accepted words.
